// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, chained add-with-carry and an iterative shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic c_st;
  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic [WIDTH-1:0] mplier, res;
  logic [5:0] cnt;
  logic [WIDTH:0] sum, dif;
  logic res_c, res_v, res_il, arith, accept, consume, done, is_mul;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign is_mul   = alu_sel == 4'd8;
  assign done     = (state == MUL) && (cnt == 6'(WIDTH - 1));
  assign zero     = alu_out == '0;
  assign neg      = alu_out[WIDTH-1];
  assign sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (alu_sel == 4'd5) && c_st};
  assign dif      = {1'b0, a} - {1'b0, b};
  assign acc_nx   = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    res    = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_il = 1'b0;
    arith  = 1'b0;
    case (alu_sel)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a ^ b;
      4'd3, 4'd5: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        arith = 1'b1;
      end
      4'd4: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
        arith = 1'b1;
      end
      4'd6: {res_c, res} = {a, 1'b0};
      4'd7: {res, res_c} = {1'b0, a};
      4'd8: res = '0;
      default: res_il = 1'b1;
    endcase
  end
  always_comb state_nx = (state == IDLE) ? ((accept && is_mul) ? MUL : IDLE) : (done ? IDLE : MUL);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_out   <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      c_st      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (consume) out_valid <= 1'b0;
      if (accept && !is_mul) begin
        alu_out   <= res;
        carry     <= res_c;
        ovf       <= res_v;
        illegal   <= res_il;
        out_valid <= 1'b1;
        if (arith) c_st <= res_c;
      end
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
      // one multiplier bit per edge, LSB first; the last edge loads the output directly from acc_nx
      if (state == MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 6'd1;
      end
      if (done) begin
        alu_out   <= acc_nx[WIDTH-1:0];
        carry     <= |acc_nx[2*WIDTH-1:WIDTH];
        ovf       <= 1'b0;
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] alu_sel = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, carry, zero, neg, ovf, illegal, out_valid;
  logic [W-1:0] alu_out;
  logic [W+4:0] obs;
  int n_chk = 0, n_fail = 0;
  bit m_cst = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_sel(alu_sel),
    .in_valid(in_valid), .in_ready(in_ready), .alu_out(alu_out),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .illegal(illegal),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  assign obs = {alu_out, carry, zero, neg, ovf, illegal};

  // Expected {result, carry, zero, neg, ovf, illegal} from plain integer arithmetic
  task automatic model(input logic [3:0] sel, input logic [W-1:0] x, input logic [W-1:0] y, output logic [W+4:0] e);
    longint ux = longint'(x), uy = longint'(y), m = longint'(1) << W, p;
    int sx = $signed(x), sy = $signed(y), hi = (1 << (W-1)) - 1, lo = -(1 << (W-1)), sr;
    logic [W-1:0] r;
    bit c, v, il;
    r = '0; c = 0; v = 0; il = 0;
    case (sel)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x ^ y;
      4'd3, 4'd5: begin
        p = ux + uy + ((sel == 4'd5) ? longint'(m_cst) : 0);
        sr = sx + sy + ((sel == 4'd5) ? int'(m_cst) : 0);
        r = W'(p); c = p >= m; v = (sr > hi) || (sr < lo); m_cst = c;
      end
      4'd4: begin
        sr = sx - sy;
        r = W'(ux - uy); c = ux < uy; v = (sr > hi) || (sr < lo); m_cst = c;
      end
      4'd6: begin r = W'(ux * 2); c = ux >= m / 2; end
      4'd7: begin r = W'(ux / 2); c = (ux % 2) == 1; end
      4'd8: begin p = ux * uy; r = W'(p); c = p >= m; end
      default: il = 1;
    endcase
    e = {r, c, r == '0, r[W-1], v, il};
  endtask

  task automatic send(input logic [3:0] sel, input logic [W-1:0] x, input logic [W-1:0] y);
    alu_sel = sel; a = x; b = y; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; m_cst = 0;
    @(negedge clk);
    n_chk++;
    if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, {W{1'b0}}, 5'b01000}) begin
      n_fail++;
      $display("FAIL reset: got valid=%b ready=%b outs=%h want valid=0 ready=1 outs=%h", out_valid, in_ready, obs, {{W{1'b0}}, 5'b01000});
    end
  endtask

  task automatic test_add_adc();
    logic [3:0] s[4] = '{4'd3, 4'd5, 4'd5, 4'd3};
    logic [W-1:0] x[4] = '{8'hF0, 8'h00, 8'h00, 8'h7F};
    logic [W-1:0] y[4] = '{8'h20, 8'h00, 8'h00, 8'h01};
    logic [W+4:0] q[$], e;
    out_ready = 1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || obs !== e) begin
          n_fail++;
          $display("FAIL add_adc[%0d]: got valid=%b outs=%h want valid=1 outs=%h", i-1, out_valid, obs, e);
        end
      end
      if (i < 4) begin send(s[i], x[i], y[i]); model(s[i], x[i], y[i], e); q.push_back(e); end
      else in_valid = 0;
    end
  endtask

  task automatic test_sub();
    logic [3:0] s[3] = '{4'd4, 4'd4, 4'd4};
    logic [W-1:0] x[3] = '{8'h80, 8'h05, 8'h01};
    logic [W-1:0] y[3] = '{8'h01, 8'h05, 8'h02};
    logic [W+4:0] q[$], e;
    out_ready = 1;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || obs !== e) begin
          n_fail++;
          $display("FAIL sub[%0d]: got valid=%b outs=%h want valid=1 outs=%h", i-1, out_valid, obs, e);
        end
      end
      if (i < 3) begin send(s[i], x[i], y[i]); model(s[i], x[i], y[i], e); q.push_back(e); end
      else in_valid = 0;
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] x, y;
    logic [W+4:0] e;
    int busy;
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      x = (k == 0) ? 8'h10 : W'($urandom);
      y = (k == 0) ? 8'h11 : W'($urandom);
      @(negedge clk);
      send(4'd8, x, y); model(4'd8, x, y, e);
      @(negedge clk);
      in_valid = 0;
      busy = 0;
      for (int i = 0; i < W; i++) begin
        if (in_ready !== 1'b0 || out_valid !== 1'b0) busy++;
        @(negedge clk);
      end
      n_chk++;
      if (busy != 0) begin
        n_fail++;
        $display("FAIL mul_busy[%0d]: got %0d cycles with ready/valid high want 0", k, busy);
      end
      n_chk++;
      if (out_valid !== 1'b1 || obs !== e) begin
        n_fail++;
        $display("FAIL mul_result[%0d] %h*%h: got valid=%b outs=%h want valid=1 outs=%h", k, x, y, out_valid, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 30;
    logic [3:0] s[N];
    logic [W-1:0] x[N], y[N];
    logic [W+4:0] q[$], e;
    int r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 14);
      s[i] = (r >= 8) ? 4'(r + 1) : 4'(r);
      x[i] = W'($urandom); y[i] = W'($urandom);
    end
    s[0] = 4'd0; s[1] = 4'd1; s[2] = 4'd2; s[3] = 4'd6; s[4] = 4'd7;
    x[3] = 8'h81; x[4] = 8'h81;
    out_ready = 1;
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || obs !== e) begin
          n_fail++;
          $display("FAIL b2b[%0d] sel=%0d: got valid=%b outs=%h want valid=1 outs=%h", i-1, s[i-1], out_valid, obs, e);
        end
      end
      if (i < N) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
        end
        send(s[i], x[i], y[i]); model(s[i], x[i], y[i], e); q.push_back(e);
      end else in_valid = 0;
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] x = W'($urandom), y = W'($urandom);
    logic [W+4:0] e;
    @(negedge clk);
    out_ready = 0;
    send(4'd2, x, y); model(4'd2, x, y, e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      send(4'd3, 8'hFF, 8'hFF);
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got valid=%b ready=%b outs=%h want valid=1 ready=0 outs=%h", i, out_valid, in_ready, obs, e);
      end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] s[5] = '{4'd3, 4'd10, 4'd15, 4'd9, 4'd5};
    logic [W-1:0] x[5] = '{8'hFF, 8'h5A, 8'hFF, 8'h01, 8'h00};
    logic [W-1:0] y[5] = '{8'h01, 8'hA5, 8'hFF, 8'h01, 8'h00};
    logic [W+4:0] q[$], e;
    out_ready = 1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || obs !== e) begin
          n_fail++;
          $display("FAIL illegal[%0d] sel=%0d: got valid=%b outs=%h want valid=1 outs=%h", i-1, s[i-1], out_valid, obs, e);
        end
      end
      if (i < 5) begin send(s[i], x[i], y[i]); model(s[i], x[i], y[i], e); q.push_back(e); end
      else in_valid = 0;
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W+4:0] e;
    int bad = 0;
    out_ready = 1;
    @(negedge clk);
    send(4'd3, 8'hFF, 8'h01); model(4'd3, 8'hFF, 8'h01, e);
    @(negedge clk);
    send(4'd8, 8'hFF, 8'hFF);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; m_cst = 0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_reset: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_mul_abort: got %0d cycles with out_valid high want 0", bad);
    end
    send(4'd5, 8'h00, 8'h00); model(4'd5, 8'h00, 8'h00, e);
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_fail++;
      $display("FAIL cst_cleared: got valid=%b outs=%h want valid=1 outs=%h", out_valid, obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_sub();
    test_mul();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
